// File: rtl/regfile_write_arbiter.sv
// Round-robin scheduler of two one-entry write slots onto the register-file write port.
// Optional: define REGWR_ZERO_SUPPRESS_EN to drop address-0 writes at acceptance.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_a,
  output logic                  ready_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  valid_b,
  output logic                  ready_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  regwrite,
  output logic [ADDR_WIDTH-1:0] writeaddr,
  output logic [DATA_WIDTH-1:0] writedata,
  output logic                  grant_src,
  output logic                  idle,
  output logic [7:0]            conflicts
);

  logic                  r_full_a;
  logic                  r_full_b;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic [DATA_WIDTH-1:0] r_data_a;
  logic [DATA_WIDTH-1:0] r_data_b;
  logic                  r_last;
  logic                  r_regwrite;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_src;
  logic [7:0]            r_conf;

  logic w_gnt_a;
  logic w_gnt_b;
  logic w_acc_a;
  logic w_acc_b;
  logic w_load_a;
  logic w_load_b;

  // r_last = 1 means B won most recently, so A wins a tie
  assign w_gnt_a = r_full_a & (~r_full_b | r_last);
  assign w_gnt_b = r_full_b & (~r_full_a | ~r_last);

  assign ready_a = ~r_full_a | w_gnt_a;
  assign ready_b = ~r_full_b | w_gnt_b;

  assign w_acc_a = valid_a & ready_a;
  assign w_acc_b = valid_b & ready_b;

`ifdef REGWR_ZERO_SUPPRESS_EN
  assign w_load_a = w_acc_a & (addr_a != '0);
  assign w_load_b = w_acc_b & (addr_b != '0);
`else
  assign w_load_a = w_acc_a;
  assign w_load_b = w_acc_b;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full_a <= 1'b0;
      r_full_b <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      r_full_a <= w_load_a | (r_full_a & ~w_gnt_a);
      r_full_b <= w_load_b | (r_full_b & ~w_gnt_b);
      if (w_load_a) begin
        r_addr_a <= addr_a;
        r_data_a <= data_a;
      end
      if (w_load_b) begin
        r_addr_b <= addr_b;
        r_data_b <= data_b;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_src      <= 1'b0;
      r_last     <= 1'b1;
    end else begin
      r_regwrite <= w_gnt_a | w_gnt_b;
      if (w_gnt_a) begin
        r_waddr <= r_addr_a;
        r_wdata <= r_data_a;
        r_src   <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_gnt_b) begin
        r_waddr <= r_addr_b;
        r_wdata <= r_data_b;
        r_src   <= 1'b1;
        r_last  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conf <= '0;
    end else if (r_full_a & r_full_b & (r_conf != 8'hFF)) begin
      r_conf <= r_conf + 8'd1;
    end
  end

  assign regwrite  = r_regwrite;
  assign writeaddr = r_waddr;
  assign writedata = r_wdata;
  assign grant_src = r_src;
  assign conflicts = r_conf;
  assign idle      = ~r_full_a & ~r_full_b & ~r_regwrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued
// by the stimulus and retired by a negedge monitor on regwrite.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_a = 1'b0;
  logic        ready_a;
  logic [4:0]  addr_a = '0;
  logic [31:0] data_a = '0;
  logic        valid_b = 1'b0;
  logic        ready_b;
  logic [4:0]  addr_b = '0;
  logic [31:0] data_b = '0;
  logic        regwrite;
  logic [4:0]  writeaddr;
  logic [31:0] writedata;
  logic        grant_src;
  logic        idle;
  logic [7:0]  conflicts;

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .valid_a(valid_a), .ready_a(ready_a),
    .addr_a(addr_a), .data_a(data_a),
    .valid_b(valid_b), .ready_b(ready_b),
    .addr_b(addr_b), .data_b(data_b),
    .regwrite(regwrite), .writeaddr(writeaddr),
    .writedata(writedata), .grant_src(grant_src),
    .idle(idle), .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  logic [37:0] q[$];
  logic [31:0] rf[32];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [37:0] ent(logic s, logic [4:0] a,
                                      logic [31:0] d);
    return {s, a, d};
  endfunction

  always @(negedge clk) begin
    if (!reset && regwrite) begin
      if (q.size() == 0) begin
        chk("unexpected_regwrite", {27'd0, writeaddr}, 32'hFFFF_FFFF);
      end else begin
        logic [37:0] e;
        e = q.pop_front();
        chk("grant_src", {31'd0, grant_src}, {31'd0, e[37]});
        chk("writeaddr", {27'd0, writeaddr}, {27'd0, e[36:32]});
        chk("writedata", writedata, e[31:0]);
      end
      if (writeaddr != 5'd0) rf[writeaddr] = writedata;
    end
  end

  task automatic send(logic s, logic [4:0] a, logic [31:0] d);
    int c;
    @(negedge clk);
    if (s) begin
      valid_b = 1'b1; addr_b = a; data_b = d;
    end else begin
      valid_a = 1'b1; addr_a = a; data_a = d;
    end
    c = 0;
    while (!(s ? ready_b : ready_a) && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) chk("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic drain();
    int c;
    c = 0;
    @(negedge clk);
    while ((q.size() != 0 || !idle) && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("drain", {31'd0, c < 400}, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic stream(int n, int off);
    for (int i = 0; i < n; i++) begin
      q.push_back(ent(1'b0, 5'(1 + (i % 15)), 32'hA000 + 32'(i + off)));
      q.push_back(ent(1'b1, 5'(16 + (i % 15)), 32'hB000 + 32'(i + off)));
    end
    fork
      begin
        for (int i = 0; i < n; i++)
          send(1'b0, 5'(1 + (i % 15)), 32'hA000 + 32'(i + off));
        @(negedge clk);
        valid_a = 1'b0;
      end
      begin
        for (int j = 0; j < n; j++)
          send(1'b1, 5'(16 + (j % 15)), 32'hB000 + 32'(j + off));
        @(negedge clk);
        valid_b = 1'b0;
      end
    join
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    @(negedge clk);
    chk("rst_regwrite", {31'd0, regwrite}, 0);
    chk("rst_writeaddr", {27'd0, writeaddr}, 0);
    chk("rst_writedata", writedata, 0);
    chk("rst_grant_src", {31'd0, grant_src}, 0);
    chk("rst_conflicts", {24'd0, conflicts}, 0);
    chk("rst_ready", {30'd0, ready_a, ready_b}, 3);
    chk("rst_idle", {31'd0, idle}, 1);
    reset = 1'b0;

    // single uncontested write
    q.push_back(ent(1'b0, 5'd3, 32'hDEAD_BEEF));
    send(1'b0, 5'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    valid_a = 1'b0;
    chk("lat_n_plus_0", {31'd0, regwrite}, 0);
    @(negedge clk);
    chk("lat_n_plus_1", {31'd0, regwrite}, 1);
    @(negedge clk);
    chk("pulse_width", {31'd0, regwrite}, 0);
    drain();
    chk("idle_after", {31'd0, idle}, 1);

    // back-to-back same-address ordering
    q.push_back(ent(1'b0, 5'd7, 32'hA));
    q.push_back(ent(1'b0, 5'd7, 32'hB));
    send(1'b0, 5'd7, 32'hA);
    send(1'b0, 5'd7, 32'hB);
    @(negedge clk);
    valid_a = 1'b0;
    drain();
    chk("rf7_final", rf[7], 32'hB);

    // address-0 write
`ifndef REGWR_ZERO_SUPPRESS_EN
    q.push_back(ent(1'b1, 5'd0, 32'hFFFF_FFFF));
`endif
    send(1'b1, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    valid_b = 1'b0;
    repeat (3) @(negedge clk);
    drain();

    // simultaneous acceptance
    do_reset();
    q.push_back(ent(1'b0, 5'd4, 32'h1));
    q.push_back(ent(1'b1, 5'd5, 32'h2));
    fork
      send(1'b0, 5'd4, 32'h1);
      send(1'b1, 5'd5, 32'h2);
    join
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    drain();
    chk("conflicts_pair", {24'd0, conflicts}, 1);

    // continuous dual streams and saturation
    do_reset();
    stream(10, 0);
    drain();
    chk("conflicts_19", {24'd0, conflicts}, 19);
    stream(130, 100);
    drain();
    chk("conflicts_sat", {24'd0, conflicts}, 255);

    // reset with both slots full and a write in flight
    do_reset();
    @(negedge clk);
    valid_a = 1'b1; addr_a = 5'd8; data_a = 32'h11;
    valid_b = 1'b1; addr_b = 5'd9; data_b = 32'h22;
    @(posedge clk);
    #1;
    data_a = 32'h33;
    valid_b = 1'b0;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    chk("pre_rst_regwrite", {31'd0, regwrite}, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_regwrite", {31'd0, regwrite}, 0);
    chk("mid_rst_ready", {30'd0, ready_a, ready_b}, 3);
    chk("mid_rst_conflicts", {24'd0, conflicts}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {31'd0, idle}, 1);
    chk("post_rst_ready", {30'd0, ready_a, ready_b}, 3);
    chk("post_rst_queue", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
